// File: rtl/hazard_scoreboard.sv
// Producer-side hazard tracker: holds dest/Tnew of the E and M instructions and the HI/LO busy counter,
// and raises stall when a D-stage source cannot be forwarded in time. Optional macro: HAZARD_STATS_EN.
module hazard_scoreboard #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter int CNT_W       = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       A1_D,
   input  logic [4:0]       A2_D,
   input  logic [1:0]       tuse1_D,
   input  logic [1:0]       tuse2_D,
   input  logic [4:0]       A3_D,
   input  logic [1:0]       tnew_D,
   input  logic             md_D,
   input  logic             start_D,
   input  logic             div_D,
   output logic             stall,
   output logic             en_PC,
   output logic             en_D,
   output logic             flush_E,
   output logic             busy_md
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0]      stall_cnt,
   output logic [31:0]      md_stall_cnt
`endif
);

   logic [4:0]       a3_e;
   logic [1:0]       tnew_e;
   logic             start_e;
   logic             div_e;
   logic [4:0]       a3_m;
   logic [1:0]       tnew_m;
   logic [CNT_W-1:0] cnt;

   logic             reg_stall;
   logic             md_stall;

   // A source stalls only if its producer still needs more cycles than the consumer can wait.
   function automatic logic src_hazard(input logic [4:0] a, input logic [1:0] tuse,
                                       input logic [4:0] a3e, input logic [1:0] tne,
                                       input logic [4:0] a3m, input logic [1:0] tnm);
      src_hazard = (a != 5'd0) && (tuse != 2'd3) &&
                   (((a == a3e) && (tne > tuse)) || ((a == a3m) && (tnm > tuse)));
   endfunction

   always_comb begin
      reg_stall = src_hazard(A1_D, tuse1_D, a3_e, tnew_e, a3_m, tnew_m) ||
                  src_hazard(A2_D, tuse2_D, a3_e, tnew_e, a3_m, tnew_m);
      busy_md   = !reset && (start_e || (cnt != '0));
      md_stall  = md_D && busy_md;
      stall     = !reset && (reg_stall || md_stall);
      en_PC     = !stall;
      en_D      = !stall;
      flush_E   = stall;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a3_e    <= '0;
         tnew_e  <= '0;
         start_e <= 1'b0;
         div_e   <= 1'b0;
         a3_m    <= '0;
         tnew_m  <= '0;
      end else begin
         if (stall) begin
            a3_e    <= '0;
            tnew_e  <= '0;
            start_e <= 1'b0;
            div_e   <= 1'b0;
         end else begin
            a3_e    <= A3_D;
            tnew_e  <= tnew_D;
            start_e <= start_D;
            div_e   <= div_D;
         end
         a3_m   <= a3_e;
         tnew_m <= (tnew_e == 2'd0) ? 2'd0 : tnew_e - 2'd1;
      end
   end

   // Busy spans the E cycle of the start plus N counted cycles after it.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (start_e) begin
         cnt <= div_e ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

`ifdef HAZARD_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt    <= '0;
         md_stall_cnt <= '0;
      end else begin
         if (stall)    stall_cnt    <= stall_cnt + 32'd1;
         if (md_stall) md_stall_cnt <= md_stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios with literal expectations, then random
// instruction streams checked every cycle against a time-stamped pipeline/MDU model.
module tb_hazard_scoreboard;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] A1_D, A2_D, A3_D;
   logic [1:0] tuse1_D, tuse2_D, tnew_D;
   logic       md_D, start_D, div_D;
   logic       stall, en_PC, en_D, flush_E, busy_md;
`ifdef HAZARD_STATS_EN
   logic [31:0] stall_cnt, md_stall_cnt;
`endif

   always #5 clk = ~clk;

   hazard_scoreboard dut (
      .clk(clk), .reset(reset),
      .A1_D(A1_D), .A2_D(A2_D), .tuse1_D(tuse1_D), .tuse2_D(tuse2_D),
      .A3_D(A3_D), .tnew_D(tnew_D), .md_D(md_D), .start_D(start_D), .div_D(div_D),
      .stall(stall), .en_PC(en_PC), .en_D(en_D), .flush_E(flush_E), .busy_md(busy_md)
`ifdef HAZARD_STATS_EN
      , .stall_cnt(stall_cnt), .md_stall_cnt(md_stall_cnt)
`endif
   );

   typedef struct packed {
      logic [4:0] a1, a2;
      logic [1:0] tu1, tu2;
      logic [4:0] a3;
      logic [1:0] tn;
      logic       md, st, dv;
   } d_t;

   // An in-flight instruction remembered with the Tnew it had on entering E.
   typedef struct packed {
      logic [4:0] dest;
      logic [1:0] tnew;
      logic       start;
      logic       dv;
   } slot_t;

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          busy_end = -1;
   slot_t       in_e, in_m;
   d_t          cur;
   bit          rst_cur;
   bit          exp_stall, exp_md_stall, exp_busy;
   logic [31:0] exp_stall_cnt, exp_md_cnt;

   function automatic d_t mk(int a1, int a2, int tu1, int tu2, int a3, int tn, bit md, bit st, bit dv);
      d_t d;
      d.a1 = 5'(a1); d.a2 = 5'(a2); d.tu1 = 2'(tu1); d.tu2 = 2'(tu2);
      d.a3 = 5'(a3); d.tn = 2'(tn); d.md = md; d.st = st; d.dv = dv;
      return d;
   endfunction

   // Cycles still needed before the result exists, given how long ago it entered E.
   function automatic int remaining(slot_t s, int age);
      return (int'(s.tnew) > age) ? int'(s.tnew) - age : 0;
   endfunction

   function automatic bit src_haz(int a, int tu, slot_t e, slot_t m);
      if (a == 0 || tu == 3) return 1'b0;
      return (a == int'(e.dest) && remaining(e, 0) > tu) ||
             (a == int'(m.dest) && remaining(m, 1) > tu);
   endfunction

   task automatic model_edge();
      if (rst_cur) begin
         in_e = '0;
         in_m = '0;
         busy_end = -1;
         exp_stall_cnt = '0;
         exp_md_cnt = '0;
      end else begin
         if (in_e.start) busy_end = cyc + (in_e.dv ? DIV_N : MULT_N);
         exp_stall_cnt = exp_stall_cnt + 32'(exp_stall);
         exp_md_cnt    = exp_md_cnt + 32'(exp_md_stall);
         in_m = in_e;
         if (exp_stall) in_e = '0;
         else in_e = '{dest: cur.a3, tnew: cur.tn, start: cur.st, dv: cur.dv};
      end
      cyc++;
   endtask

   task automatic model_eval();
      exp_busy     = !rst_cur && (in_e.start || cyc <= busy_end);
      exp_md_stall = cur.md && exp_busy;
      exp_stall    = !rst_cur && (src_haz(cur.a1, cur.tu1, in_e, in_m) ||
                                  src_haz(cur.a2, cur.tu2, in_e, in_m) || exp_md_stall);
   endtask

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: cycle %0d got %0d want %0d", name, cyc, act, exp);
      end
   endtask

   task automatic drive(d_t d, bit r);
      cur = d; rst_cur = r; reset = r;
      A1_D = d.a1; A2_D = d.a2; tuse1_D = d.tu1; tuse2_D = d.tu2;
      A3_D = d.a3; tnew_D = d.tn; md_D = d.md; start_D = d.st; div_D = d.dv;
   endtask

   task automatic step(d_t d, bit r);
      @(posedge clk);
      model_edge();
      #1;
      drive(d, r);
      model_eval();
      @(negedge clk);
      chk("stall", 32'(stall), 32'(exp_stall));
      chk("en_PC", 32'(en_PC), 32'(!exp_stall));
      chk("en_D", 32'(en_D), 32'(!exp_stall));
      chk("flush_E", 32'(flush_E), 32'(exp_stall));
      chk("busy_md", 32'(busy_md), 32'(exp_busy));
`ifdef HAZARD_STATS_EN
      chk("stall_cnt", stall_cnt, exp_stall_cnt);
      chk("md_stall_cnt", md_stall_cnt, exp_md_cnt);
`endif
   endtask

   d_t nop, lw8, beq8, mfhi, divi, multi, mflo;

   initial begin
      nop   = mk(0, 0, 3, 3, 0, 0, 0, 0, 0);
      lw8   = mk(0, 0, 3, 3, 8, 2, 0, 0, 0);
      beq8  = mk(8, 0, 0, 3, 0, 0, 0, 0, 0);
      mfhi  = mk(0, 0, 3, 3, 10, 1, 1, 0, 0);
      mflo  = mk(0, 0, 3, 3, 11, 1, 1, 0, 0);
      divi  = mk(4, 5, 1, 1, 0, 0, 1, 1, 1);
      multi = mk(4, 5, 1, 1, 0, 0, 1, 1, 0);
      in_e = '0; in_m = '0; exp_stall = 0; exp_md_stall = 0;
      exp_stall_cnt = '0; exp_md_cnt = '0;
      drive(nop, 1'b1);

      step(nop, 1'b1);
      chk("reset_stall", 32'(stall), 32'd0);
      chk("reset_en_pc", 32'(en_PC), 32'd1);
      chk("reset_busy", 32'(busy_md), 32'd0);
      step(nop, 1'b1);

      // lw $8 then a branch on $8: two stall cycles, then release.
      step(lw8, 1'b0);
      step(beq8, 1'b0);
      chk("lw_use_stall_e", 32'(stall), 32'd1);
      chk("lw_use_flush_e", 32'(flush_E), 32'd1);
      step(beq8, 1'b0);
      chk("lw_use_stall_m", 32'(stall), 32'd1);
      step(beq8, 1'b0);
      chk("lw_use_release", 32'(stall), 32'd0);

      // div then mfhi: MD stall for 1 + DIV_N cycles.
      step(divi, 1'b0);
      for (int i = 0; i < 12; i++) begin
         step(mfhi, 1'b0);
         chk("div_mfhi_stall", 32'(stall), (i < 11) ? 32'd1 : 32'd0);
         chk("div_mfhi_busy", 32'(busy_md), (i < 11) ? 32'd1 : 32'd0);
      end
`ifdef HAZARD_STATS_EN
      chk("stats_stall_lit", stall_cnt, 32'd13);
      chk("stats_md_lit", md_stall_cnt, 32'd11);
`endif

      // ALU producer: tuse=1 consumer forwards, branch consumer waits one cycle.
      step(mk(0, 0, 3, 3, 9, 1, 0, 0, 0), 1'b0);
      step(mk(9, 0, 1, 3, 12, 1, 0, 0, 0), 1'b0);
      chk("alu_tuse1", 32'(stall), 32'd0);
      step(mk(0, 0, 3, 3, 9, 1, 0, 0, 0), 1'b0);
      step(mk(0, 9, 3, 0, 0, 0, 0, 0, 0), 1'b0);
      chk("alu_branch_stall", 32'(stall), 32'd1);
      step(mk(0, 9, 3, 0, 0, 0, 0, 0, 0), 1'b0);
      chk("alu_branch_release", 32'(stall), 32'd0);

      // $0 and unread sources never stall.
      step(mk(0, 0, 3, 3, 0, 2, 0, 0, 0), 1'b0);
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
      chk("reg0_no_stall", 32'(stall), 32'd0);
      step(lw8, 1'b0);
      step(mk(8, 8, 3, 3, 0, 0, 0, 0, 0), 1'b0);
      chk("tuse3_no_stall", 32'(stall), 32'd0);

      // mult then reset while the counter is at 3: busy abandoned.
      step(multi, 1'b0);
      step(nop, 1'b0);
      chk("mult_busy_e", 32'(busy_md), 32'd1);
      step(nop, 1'b0);
      step(nop, 1'b0);
      step(nop, 1'b1);
      chk("mult_reset_busy", 32'(busy_md), 32'd0);
      step(mflo, 1'b0);
      chk("mflo_after_reset", 32'(stall), 32'd0);
      chk("mflo_after_reset_busy", 32'(busy_md), 32'd0);

      // Random instruction stream; D is held while stalled, as the pipeline would.
      for (int i = 0; i < 1500; i++) begin
         d_t d;
         bit r;
         r = ($urandom_range(0, 49) == 0);
         if (exp_stall) begin
            d = cur;
         end else begin
            d.a1 = 5'($urandom_range(0, 7));
            d.a2 = 5'($urandom_range(0, 7));
            d.tu1 = 2'($urandom_range(0, 3));
            d.tu2 = 2'($urandom_range(0, 3));
            d.a3 = 5'($urandom_range(0, 7));
            d.tn = 2'($urandom_range(0, 2));
            d.md = ($urandom_range(0, 3) == 0);
            d.st = d.md && ($urandom_range(0, 1) == 1);
            d.dv = ($urandom_range(0, 1) == 1);
         end
         step(d, r);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
